// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: RESETB/BYPASS sequencer for an SB_PLL40-class PLL with lock filter, retry, fail and lock-loss count.
// Define PLL_BYPASS_FALLBACK_EN to turn FAIL into a degraded bypass-run state.
module pll_lock_supervisor #(
   parameter int RESET_CYCLES   = 16,
   parameter int LOCK_FILTER    = 256,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int RELEASE_CYCLES = 64,
   parameter int RETRY_MAX      = 4,
   parameter int CNT_W          = 8
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             locked_in,
   input  logic             clear_count,
   output logic             pll_resetb,
   output logic             pll_bypass,
   output logic             reset_out,
   output logic             ready,
   output logic             fail,
   output logic [CNT_W-1:0] lock_loss_count
);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = $clog2(RELEASE_CYCLES + 1);
   localparam int YW = $clog2(RETRY_MAX + 1);
`ifdef PLL_BYPASS_FALLBACK_EN
   localparam bit FALLBACK = 1'b1;
`else
   localparam bit FALLBACK = 1'b0;
`endif

   typedef enum logic [2:0] {S_RESET_PLL, S_WAIT_LOCK, S_RELEASE, S_RUN, S_FAIL} state_t;

   state_t           state_q;
   logic             s1_q, sync_q;
   logic [RW-1:0]    rst_cnt_q;
   logic [FW-1:0]    flt_q, flt_d;
   logic [TW-1:0]    tmo_q;
   logic [LW-1:0]    rel_q;
   logic [YW-1:0]    retry_q, retry_d;
   logic [CNT_W-1:0] llc_q, llc_d;
   logic             pll_resetb_q, pll_bypass_q, reset_out_q, ready_q, fail_q;
   logic             lock_ok, timeout, loss, attempt_fail;

   always_comb begin
      flt_d        = sync_q ? flt_q + FW'(1) : '0;
      lock_ok      = flt_d == FW'(LOCK_FILTER);
      timeout      = tmo_q == TW'(TIMEOUT_CYCLES - 1);
      retry_d      = retry_q + YW'(1);
      loss         = state_q == S_RUN && !sync_q;
      // lock wins over a simultaneous timeout; a drop during RELEASE is a failed attempt, not a lock loss
      attempt_fail = (state_q == S_WAIT_LOCK && !lock_ok && timeout) || (state_q == S_RELEASE && !sync_q);
      llc_d        = (loss && clear_count) ? CNT_W'(1) :
                     clear_count ? '0 :
                     (loss && !(&llc_q)) ? llc_q + CNT_W'(1) : llc_q;
   end

   always_ff @(posedge clock_in) begin
      s1_q   <= locked_in;
      sync_q <= s1_q;
      if (reset) begin
         state_q      <= S_RESET_PLL;
         rst_cnt_q    <= '0;
         flt_q        <= '0;
         tmo_q        <= '0;
         rel_q        <= '0;
         retry_q      <= '0;
         llc_q        <= '0;
         pll_resetb_q <= 1'b0;
         pll_bypass_q <= 1'b0;
         reset_out_q  <= 1'b1;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         llc_q <= llc_d;
         if (attempt_fail) begin
            retry_q      <= retry_d;
            rst_cnt_q    <= '0;
            rel_q        <= '0;
            pll_resetb_q <= 1'b0;
            reset_out_q  <= 1'b1;
            ready_q      <= 1'b0;
            if (retry_d == YW'(RETRY_MAX)) begin
               state_q      <= S_FAIL;
               fail_q       <= 1'b1;
               pll_bypass_q <= FALLBACK;
            end else begin
               state_q <= S_RESET_PLL;
            end
         end else begin
            case (state_q)
               S_RESET_PLL: begin
                  flt_q <= '0;
                  tmo_q <= '0;
                  if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
                     state_q      <= S_WAIT_LOCK;
                     pll_resetb_q <= 1'b1;
                  end else begin
                     rst_cnt_q <= rst_cnt_q + RW'(1);
                  end
               end
               S_WAIT_LOCK: begin
                  flt_q <= flt_d;
                  tmo_q <= tmo_q + TW'(1);
                  if (lock_ok) begin
                     state_q <= S_RELEASE;
                     rel_q   <= '0;
                  end
               end
               S_RELEASE: begin
                  if (rel_q == LW'(RELEASE_CYCLES - 1)) begin
                     state_q     <= S_RUN;
                     reset_out_q <= 1'b0;
                     ready_q     <= 1'b1;
                     retry_q     <= '0;
                  end else begin
                     rel_q <= rel_q + LW'(1);
                  end
               end
               S_RUN: begin
                  if (!sync_q) begin
                     state_q      <= S_RESET_PLL;
                     rst_cnt_q    <= '0;
                     pll_resetb_q <= 1'b0;
                     reset_out_q  <= 1'b1;
                     ready_q      <= 1'b0;
                  end
               end
               S_FAIL: begin
                  // degraded run: release downstream reset on the bypassed reference clock
                  if (FALLBACK && !ready_q) begin
                     if (rel_q == LW'(RELEASE_CYCLES - 1)) begin
                        reset_out_q <= 1'b0;
                        ready_q     <= 1'b1;
                     end else begin
                        rel_q <= rel_q + LW'(1);
                     end
                  end
               end
               default: state_q <= S_RESET_PLL;
            endcase
         end
      end
   end

   assign pll_resetb      = pll_resetb_q;
   assign pll_bypass      = pll_bypass_q;
   assign reset_out       = reset_out_q;
   assign ready           = ready_q;
   assign fail            = fail_q;
   assign lock_loss_count = llc_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed stimulus with an output-change scoreboard for pll_lock_supervisor.
// Build with PLL_BYPASS_FALLBACK_EN to exercise the bypass fallback.
module tb_pll_lock_supervisor;
`ifdef PLL_BYPASS_FALLBACK_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       locked_in = 1'b0;
   logic       clear_count = 1'b0;
   logic       pll_resetb, pll_bypass, reset_out, ready, fail;
   logic [3:0] lock_loss_count;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int m_cnt = 0;

   typedef struct {
      int         c;
      logic [8:0] v;
   } ev_t;
   ev_t        q[$];
   logic [8:0] prev = 9'h1FF;

   pll_lock_supervisor #(
      .RESET_CYCLES(4), .LOCK_FILTER(8), .TIMEOUT_CYCLES(64),
      .RELEASE_CYCLES(16), .RETRY_MAX(3), .CNT_W(4)
   ) dut (
      .clock_in(clk), .reset(reset), .locked_in(locked_in), .clear_count(clear_count),
      .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .reset_out(reset_out),
      .ready(ready), .fail(fail), .lock_loss_count(lock_loss_count)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] mk(input bit rb, input bit byp, input bit ro, input bit rd,
                                     input bit fl, input int c);
      return {rb, byp, ro, rd, fl, 4'(c)};
   endfunction

   task automatic push(input int c, input logic [8:0] v);
      ev_t e;
      e.c = c;
      e.v = v;
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // every change of the output vector must match the next expected event, in time and value
   always @(negedge clk) begin
      logic [8:0] o;
      ev_t        e;
      o = {pll_resetb, pll_bypass, reset_out, ready, fail, lock_loss_count};
      if (cyc >= 1 && o !== prev) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: cyc=%0d out=%b, no change expected", cyc, o);
         end else begin
            e = q.pop_front();
            if (e.c != cyc || e.v !== o) begin
               errors++;
               $display("FAIL event: got cyc=%0d out=%b, expected cyc=%0d out=%b", cyc, o, e.c, e.v);
            end
         end
         prev = o;
      end
   end

   task automatic drop(input bit clr);
      int t;
      t = cyc;
      m_cnt = clr ? 1 : (m_cnt < 15 ? m_cnt + 1 : 15);
      push(t + 3, mk(0, 0, 1, 0, 0, m_cnt));
      push(t + 7, mk(1, 0, 1, 0, 0, m_cnt));
      push(t + 33, mk(1, 0, 0, 1, 0, m_cnt));
      locked_in = 1'b0;
      tick(2);
      clear_count = clr;
      tick(1);
      clear_count = 1'b0;
      tick(4);
      locked_in = 1'b1;
      tick(29);
   endtask

   initial begin
      int t;
      // power-up reset and first lock
      push(1, mk(0, 0, 1, 0, 0, 0));
      push(6, mk(1, 0, 1, 0, 0, 0));
      push(42, mk(1, 0, 0, 1, 0, 0));
      tick(2);
      reset = 1'b0;
      tick(14);
      locked_in = 1'b1;
      tick(29);
      // lock loss, then relock through two short glitches
      t = cyc;
      m_cnt = m_cnt + 1;
      push(t + 3, mk(0, 0, 1, 0, 0, m_cnt));
      push(t + 7, mk(1, 0, 1, 0, 0, m_cnt));
      push(t + 51, mk(1, 0, 0, 1, 0, m_cnt));
      locked_in = 1'b0;
      tick(7);
      locked_in = 1'b1;
      tick(5);
      locked_in = 1'b0;
      tick(3);
      locked_in = 1'b1;
      tick(7);
      locked_in = 1'b0;
      tick(3);
      locked_in = 1'b1;
      tick(29);
      // repeated drops: saturation, then clear coincident with a drop
      for (int i = 0; i < 20; i++) drop(i == 19);
      t = cyc;
      m_cnt = 0;
      push(t + 1, mk(1, 0, 0, 1, 0, 0));
      clear_count = 1'b1;
      tick(1);
      clear_count = 1'b0;
      tick(3);
      // RELEASE drop, timeout, resets mid-RELEASE and mid-WAIT_LOCK, then exhaust retries
      t = cyc;
      m_cnt = m_cnt + 1;
      push(t + 3, mk(0, 0, 1, 0, 0, m_cnt));
      push(t + 7, mk(1, 0, 1, 0, 0, m_cnt));
      push(t + 23, mk(0, 0, 1, 0, 0, m_cnt));
      push(t + 27, mk(1, 0, 1, 0, 0, m_cnt));
      push(t + 91, mk(0, 0, 1, 0, 0, m_cnt));
      push(t + 95, mk(1, 0, 1, 0, 0, m_cnt));
      push(t + 111, mk(0, 0, 1, 0, 0, 0));
      push(t + 115, mk(1, 0, 1, 0, 0, 0));
      push(t + 179, mk(0, 0, 1, 0, 0, 0));
      push(t + 183, mk(1, 0, 1, 0, 0, 0));
      push(t + 191, mk(0, 0, 1, 0, 0, 0));
      push(t + 195, mk(1, 0, 1, 0, 0, 0));
      push(t + 259, mk(0, 0, 1, 0, 0, 0));
      push(t + 263, mk(1, 0, 1, 0, 0, 0));
      push(t + 327, mk(0, 0, 1, 0, 0, 0));
      push(t + 331, mk(1, 0, 1, 0, 0, 0));
      push(t + 395, mk(0, BYP, 1, 0, 1, 0));
      if (BYP) push(t + 411, mk(0, 1, 0, 1, 1, 0));
      locked_in = 1'b0;
      tick(7);
      locked_in = 1'b1;
      tick(13);
      locked_in = 1'b0;
      tick(75);
      locked_in = 1'b1;
      tick(15);
      reset = 1'b1;
      locked_in = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(79);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(204);
      // FAIL must hold regardless of locked_in
      for (int i = 0; i < 1000; i++) begin
         if (i % 37 == 0) locked_in = ~locked_in;
         tick(1);
      end
      tick(2);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: %0d expected changes never seen, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
